// File: rtl/obuf_drain_ctrl.sv
// obuf_drain_ctrl: read-side controller for the output buffer.
// Walks ARRAY_M column RAMs column-major, issuing one read per cycle while
// skid-FIFO credit allows, and streams the returned words on a valid/ready
// port. A small valid shift register tracks reads that are still in the RAM
// pipeline so downstream backpressure can never cause a dropped word.
module obuf_drain_ctrl #(
    parameter int RAM_SIZE   = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int ARRAY_M    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH:0]        num_rows,
    input  logic [$clog2(ARRAY_M):0]   num_cols,
    output logic [$clog2(ARRAY_M)-1:0] ram_idx,
    output logic [ADDR_WIDTH-1:0]      read_addr,
    input  logic [DATA_WIDTH-1:0]      data_read,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int IDX_W = $clog2(ARRAY_M);
    localparam int COL_W = IDX_W + 1;
    localparam int ROW_W = ADDR_WIDTH + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state, next_state;

    // Latched drain geometry and walk counters
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ROW_W-1:0]      nrows_q;
    logic [COL_W-1:0]      ncols_q;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      col;
    logic [IDX_W-1:0]      idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // In-flight read tracking (valid and last-tag pipelines)
    logic [RD_LATENCY-1:0] vld;
    logic [RD_LATENCY-1:0] lst;

    // Skid FIFO
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  accept, issue, push, push_last, pop;
    logic                  row_end, col_end, last_issue;
    logic [CNT_W-1:0]      inflight, occupancy;
    logic [COL_W-1:0]      cols_clamped;
    logic [ADDR_WIDTH-1:0] issue_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign cols_clamped = (num_cols > COL_W'(ARRAY_M)) ? COL_W'(ARRAY_M) : num_cols;
    assign row_end      = (row == nrows_q - ROW_W'(1));
    assign col_end      = (col == ncols_q - COL_W'(1));
    assign last_issue   = row_end && col_end;
    assign issue_addr   = base_q + row[ADDR_WIDTH-1:0];
    assign push         = vld[RD_LATENCY-1];
    assign push_last    = lst[RD_LATENCY-1];
    assign pop          = out_valid && out_ready;

    // Count reads still travelling through the RAM pipeline; credit uses only registered state
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vld[i]);
        end
        occupancy = fifo_count + inflight;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0 || num_cols == '0) next_state = FIN;
                    else                                  next_state = ISSUE;
                end
            end
            ISSUE: if (issue && last_issue) next_state = DRAIN;
            DRAIN: if (inflight == '0 && pop && out_last) next_state = FIN;
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: start acceptance, read issue under credit, busy and done
    always_comb begin
        accept = (state == IDLE) && start;
        issue  = (state == ISSUE) && (occupancy < CNT_W'(FIFO_DEPTH));
        busy   = (state != IDLE) || start;
        done   = (state == FIN);
    end

    // Geometry latch on accepted start, row-major-within-column walk, held read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q  <= '0;
            nrows_q <= '0;
            ncols_q <= '0;
            row     <= '0;
            col     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else if (accept) begin
            base_q  <= base_addr;
            nrows_q <= num_rows;
            ncols_q <= cols_clamped;
            row     <= '0;
            col     <= '0;
        end else if (issue) begin
            idx_q  <= col[IDX_W-1:0];
            addr_q <= issue_addr;
            if (row_end) begin
                row <= '0;
                col <= col + COL_W'(1);
            end else begin
                row <= row + ROW_W'(1);
            end
        end
    end

    // Read port shows the address being issued; otherwise it holds the last issued one
    always_comb begin
        ram_idx   = issue ? col[IDX_W-1:0] : idx_q;
        read_addr = issue ? issue_addr     : addr_q;
    end

    // In-flight shift registers: a read's data is pushed when its valid bit emerges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            lst <= '0;
        end else begin
            vld[0] <= issue;
            lst[0] <= issue && last_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                lst[i] <= lst[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; entries are only observed when fifo_count says they are valid.
        if (push) begin
            fifo_data[wr_ptr] <= data_read;
            fifo_last[wr_ptr] <= push_last;
        end
    end

    // Stream port: head of FIFO, forced to zero when empty
    always_comb begin
        out_valid = (fifo_count != '0);
        out_data  = out_valid ? fifo_data[rd_ptr] : '0;
        out_last  = out_valid && fifo_last[rd_ptr];
    end

    // Credit must make overflow impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// Testbench for obuf_drain_ctrl. Two instances (RD_LATENCY 1 and 2) run the
// same directed stimulus against a synchronous RAM model; a bench-side model
// of the drain (expected word list, busy/done timing) is checked every cycle.
module tb_obuf_drain_ctrl;

    localparam int NI = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_rows = '0;
    logic [IW:0]   num_cols = '0;

    logic [IW-1:0] ram_idx_w   [NI];
    logic [AW-1:0] read_addr_w [NI];
    logic [DW-1:0] data_read_w [NI];
    logic [DW-1:0] d1          [NI];
    logic [DW-1:0] d2          [NI];
    logic [DW-1:0] out_data_w  [NI];
    logic          out_valid_w [NI];
    logic          out_last_w  [NI];
    logic          busy_w      [NI];
    logic          done_w      [NI];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit bp_mode = 1'b0;
    logic [3:0] ready_pat = 4'b1001;

    // Drain model state per instance
    int          m_base [NI], m_rows [NI], m_cols [NI], m_total [NI], m_idx [NI];
    bit          m_busy [NI], m_done [NI];
    bit          stall_prev [NI];
    logic [DW-1:0] stall_data [NI];
    logic        stall_last [NI];
    int          beat_cnt [NI], start_cyc [NI], fv_cyc [NI], done_cyc [NI];
    bit          fv_seen [NI];
    logic [DW-1:0] first_data [NI], last_data [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        obuf_drain_ctrl #(.RD_LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .base_addr (base_addr),
            .num_rows  (num_rows),
            .num_cols  (num_cols),
            .ram_idx   (ram_idx_w[g]),
            .read_addr (read_addr_w[g]),
            .data_read (data_read_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g]),
            .out_last  (out_last_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g])
        );
        assign data_read_w[g] = (g == 0) ? d1[g] : d2[g];
    end

    // Column m, row address a holds {m, a}
    function automatic logic [31:0] ram_word(input int m, input int a);
        return (32'(m) << 16) | 32'(a);
    endfunction

    // Synchronous buffer RAM with one or two cycles of read latency
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            d1[g] <= ram_word(int'(ram_idx_w[g]), int'(read_addr_w[g]));
            d2[g] <= d1[g];
        end
    end

    function automatic logic [31:0] exp_word(input int g, input int k);
        int c, r;
        c = k / m_rows[g];
        r = k % m_rows[g];
        return ram_word(c, (m_base[g] + r) % 256);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the drain model, sampled at the falling edge
    task automatic compare_all();
        for (int g = 0; g < NI; g++) begin
            if (!reset) begin
                check($sformatf("reset_outs%0d", g),
                      {ram_idx_w[g], read_addr_w[g], out_valid_w[g], out_data_w[g],
                       out_last_w[g], busy_w[g], done_w[g]}, 64'd0);
                m_busy[g] = 1'b0;
                m_done[g] = 1'b0;
                stall_prev[g] = 1'b0;
            end else begin
                bit nb, nd;
                check($sformatf("busy%0d", g), busy_w[g], m_busy[g] || start);
                check($sformatf("done%0d", g), done_w[g], m_done[g]);
                if (stall_prev[g]) begin
                    check($sformatf("hold_valid%0d", g), out_valid_w[g], 1'b1);
                    check($sformatf("hold_data%0d", g), out_data_w[g], stall_data[g]);
                    check($sformatf("hold_last%0d", g), out_last_w[g], stall_last[g]);
                end
                nb = m_busy[g];
                nd = 1'b0;
                if (out_valid_w[g] && m_busy[g] && !fv_seen[g]) begin
                    fv_seen[g] = 1'b1;
                    fv_cyc[g] = cyc;
                end
                if (out_valid_w[g] && out_ready) begin
                    check($sformatf("beat_in_range%0d", g), m_busy[g] && (m_idx[g] < m_total[g]), 1'b1);
                    if (m_busy[g] && m_idx[g] < m_total[g]) begin
                        check($sformatf("beat_data%0d", g), out_data_w[g], exp_word(g, m_idx[g]));
                        check($sformatf("beat_last%0d", g), out_last_w[g], m_idx[g] == m_total[g] - 1);
                        if (m_idx[g] == m_total[g] - 1) nd = 1'b1;
                        if (beat_cnt[g] == 0) first_data[g] = out_data_w[g];
                        last_data[g] = out_data_w[g];
                        m_idx[g]++;
                        beat_cnt[g]++;
                    end
                end
                stall_prev[g] = out_valid_w[g] && !out_ready;
                stall_data[g] = out_data_w[g];
                stall_last[g] = out_last_w[g];
                if (m_done[g]) begin
                    nb = 1'b0;
                    done_cyc[g] = cyc;
                end
                if (start && !m_busy[g]) begin
                    m_base[g]  = int'(base_addr);
                    m_rows[g]  = int'(num_rows);
                    m_cols[g]  = (int'(num_cols) > 8) ? 8 : int'(num_cols);
                    m_total[g] = m_rows[g] * m_cols[g];
                    m_idx[g]   = 0;
                    beat_cnt[g] = 0;
                    fv_seen[g] = 1'b0;
                    start_cyc[g] = cyc;
                    nb = 1'b1;
                    if (m_total[g] == 0) nd = 1'b1;
                end
                m_busy[g] = nb;
                m_done[g] = nd;
            end
        end
    endtask

    // One clock: compare at the falling edge, then update inputs just after the rising edge
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        out_ready = bp_mode ? ready_pat[cyc % 4] : 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_busy[0] || m_busy[1]) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_completes", !(m_busy[0] || m_busy[1]), 1'b1);
    endtask

    task automatic run_drain(input int base, input int rows, input int cols, input int budget);
        base_addr = AW'(base);
        num_rows  = (AW + 1)'(rows);
        num_cols  = (IW + 1)'(cols);
        start = 1'b1;
        cycle();
        wait_idle(budget);
        cycle();
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            m_busy[g] = 1'b0; m_done[g] = 1'b0; stall_prev[g] = 1'b0;
            beat_cnt[g] = 0; fv_seen[g] = 1'b0; m_idx[g] = 0; m_total[g] = 0;
            m_rows[g] = 1; m_cols[g] = 0; m_base[g] = 0;
            start_cyc[g] = 0; fv_cyc[g] = 0; done_cyc[g] = 0;
            first_data[g] = '0; last_data[g] = '0;
        end

        // Reset held for a few cycles
        repeat (3) cycle();
        reset = 1'b1;
        repeat (2) cycle();

        // Basic drain, 3 rows x 2 columns from 0x10, full throughput
        run_drain(8'h10, 3, 2, 100);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("basic_beats%0d", g), beat_cnt[g], 6);
            check($sformatf("basic_first%0d", g), first_data[g], 32'h0000_0010);
            check($sformatf("basic_last%0d", g), last_data[g], 32'h0001_0012);
            check($sformatf("first_valid_lat%0d", g), fv_cyc[g] - start_cyc[g], g + 3);
            check($sformatf("drain_cycles%0d", g), done_cyc[g] - start_cyc[g], g + 9);
        end

        // Address wrap-around; read port holds the last issued address afterwards
        run_drain(8'hFE, 4, 1, 100);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("wrap_beats%0d", g), beat_cnt[g], 4);
            check($sformatf("wrap_last%0d", g), last_data[g], 32'h0000_0001);
            check($sformatf("wrap_hold_addr%0d", g), read_addr_w[g], 8'h01);
            check($sformatf("wrap_hold_idx%0d", g), ram_idx_w[g], 3'd0);
        end

        // Zero-size drains
        run_drain(8'h00, 5, 0, 20);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("zero_cols_beats%0d", g), beat_cnt[g], 0);
            check($sformatf("zero_cols_done%0d", g), done_cyc[g] - start_cyc[g], 1);
        end
        run_drain(8'h00, 0, 3, 20);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("zero_rows_beats%0d", g), beat_cnt[g], 0);
        end

        // Column count above ARRAY_M clamps to 8
        run_drain(8'h20, 2, 12, 200);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("clamp_beats%0d", g), beat_cnt[g], 16);
            check($sformatf("clamp_last%0d", g), last_data[g], 32'h0007_0021);
        end

        // Backpressure 1,0,0,1 on a 4x8 drain with an ignored start mid-drain
        bp_mode = 1'b1;
        base_addr = 8'h00; num_rows = 9'd4; num_cols = 4'd8;
        start = 1'b1;
        cycle();
        repeat (5) cycle();
        base_addr = 8'h80; num_rows = 9'd1; num_cols = 4'd1;
        start = 1'b1;
        cycle();
        wait_idle(400);
        cycle();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("bp_beats%0d", g), beat_cnt[g], 32);
            check($sformatf("bp_last%0d", g), last_data[g], 32'h0007_0003);
        end
        bp_mode = 1'b0;
        out_ready = 1'b1;

        // Reset after beat 5 of 16, then a full restart
        base_addr = 8'h40; num_rows = 9'd4; num_cols = 4'd4;
        start = 1'b1;
        cycle();
        begin
            int n;
            n = 0;
            while (beat_cnt[0] < 5 && n < 200) begin
                cycle();
                n++;
            end
        end
        check("reached_beat5", beat_cnt[0], 5);
        reset = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("async_reset_outs%0d", g),
                  {ram_idx_w[g], read_addr_w[g], out_valid_w[g], out_data_w[g],
                   out_last_w[g], busy_w[g], done_w[g]}, 64'd0);
        end
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        run_drain(8'h40, 4, 4, 200);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("restart_beats%0d", g), beat_cnt[g], 16);
            check($sformatf("restart_first%0d", g), first_data[g], 32'h0000_0040);
            check($sformatf("restart_last%0d", g), last_data[g], 32'h0003_0043);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obuf_drain_ctrl.md
Name: obuf_drain_ctrl

Overview:
- Read-side controller for the output buffer: after a tile's results are written into the ARRAY_M column RAMs, it walks them column-major and streams each word out on a valid/ready interface, e.g. to the writeback DMA.
- Drives the buffer's ram_idx/read_addr read port.
- Absorbs the RAM read latency with a small skid FIFO so downstream backpressure never drops data.

Parameters:
- RAM_SIZE, 256, words per column RAM.
- ADDR_WIDTH, $clog2(RAM_SIZE), RAM address width.
- ARRAY_M, 8, number of column RAMs.
- DATA_WIDTH, 32, word width.
- RD_LATENCY, 1, cycles from address to valid read data; legal values are 1 and 2.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- start  in  1  one-cycle request to begin a drain; ignored while busy.
- base_addr  in  ADDR_WIDTH  first row address in every column; sampled on accepted start.
- num_rows  in  ADDR_WIDTH+1  rows per column, 0..RAM_SIZE; sampled on accepted start.
- num_cols  in  $clog2(ARRAY_M)+1  columns to drain; values > ARRAY_M are clamped to ARRAY_M; sampled on start.
- ram_idx  out  $clog2(ARRAY_M)  column select to the buffer read port.
- read_addr  out  ADDR_WIDTH  row address to the buffer read port.
- data_read  in  DATA_WIDTH  read data from the buffer, valid RD_LATENCY cycles after the address.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  high on the final beat of the drain.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the final beat handshake.

Behaviour:
- Reset values: ram_idx=0, read_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Reset also empties the FIFO, clears in-flight tracking and returns the FSM to IDLE.
- Reset asserted mid-drain aborts the drain with no done pulse; any in-flight read data is discarded.
- FSM states:
  - IDLE: on start, latch base, num_rows and clamped num_cols; clear the column and row counters; go to ISSUE. If num_rows==0 or num_cols==0, go to FIN instead.
  - ISSUE: one read per cycle while credit is available: ram_idx=col, read_addr=base_addr+row, computed modulo 2^ADDR_WIDTH (wrap-around is legal). Order: row increments first; when row==num_rows-1, row returns to 0 and col increments. After issuing (col=num_cols-1, row=num_rows-1), go to DRAIN.
  - DRAIN: wait until no reads are in flight and the final beat has handshaken, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=1; next state IDLE.
- Credit rule: a read issues in a cycle only if (fifo_count + inflight) < FIFO_DEPTH. A slot freed by a pop in the same cycle does not count until the next cycle.
- In-flight tracking: an RD_LATENCY-deep valid shift register. data_read is pushed into the FIFO on the cycle its valid bit emerges. The FIFO never overflows; overflow is an assertion failure.
- Idle read port: when not issuing, ram_idx and read_addr hold their last values.
- Stream output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A pop occurs on out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - Push and pop in the same cycle leave the count unchanged.
  - out_last is tagged on the word of the last issued read.
- Throughput: with out_ready held at 1 and FIFO_DEPTH >= RD_LATENCY+1, one word per cycle. First out_valid appears RD_LATENCY+1 cycles after start is sampled.
- Beat count: total beats = num_rows*num_cols exactly.
- start while busy: ignored, with no effect on latched parameters.
- Zero-size drain: start with a zero dimension gives busy for 2 cycles (IDLE->FIN->IDLE), a done pulse, and no beats.

Test Plan:
- Basic drain: preload column m row r with {m,r}; start with base=0x10, num_rows=3, num_cols=2, out_ready=1 -> 6 beats, col0 rows 0x10..0x12 then col1. out_last on beat 6 only; done one cycle after that handshake.
- Backpressure: out_ready toggles 1,0,0,1 repeating, drain 4x8 -> 32 beats in order with no loss or duplication; out_data stable while stalled; FIFO count never exceeds FIFO_DEPTH.
- Wrap-around: base=0xFE, num_rows=4, num_cols=1 -> read_addr sequence 0xFE,0xFF,0x00,0x01.
- Degenerate inputs: num_cols=0 -> done after 2 cycles, zero beats. num_cols=12 with ARRAY_M=8 -> clamps to 8 columns.
- Reset and restart: assert reset low after beat 5 of 16 -> all outputs 0 immediately. Release reset and start again -> the full 16 beats are delivered from the beginning.
- Start while busy: start pulse mid-drain with different base -> ignored; the original sequence completes unchanged. RD_LATENCY=2 variant still achieves 1 beat/cycle with out_ready=1.
